// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register with MEM/WB operand forwarding and valid/ready handshake.
// Define EX_FORWARD_EN for forwarding + stall refresh; otherwise decode interlocks on EX/MEM hazards.
module ex_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rd1,
  input  logic [XLEN-1:0] id_rd2,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_immext,
  input  logic            id_alusrc,
  input  logic [2:0]      id_alucontrol,
  input  logic            id_regwrite,
  input  logic            mem_regwrite,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_result,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_srca,
  output logic [XLEN-1:0] ex_srcb,
  output logic [XLEN-1:0] ex_writedata,
  output logic [2:0]      ex_alucontrol,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_immext,
  output logic [4:0]      ex_rd,
  output logic            ex_regwrite
);
  logic            valid_q, alusrc_q, regwrite_q;
  logic [XLEN-1:0] pc_q, rd1_q, rd2_q, imm_q;
  logic [4:0]      rd_q;
  logic [2:0]      alu_q;
  logic [XLEN-1:0] opa, opb;
  logic            load;
`ifdef EX_FORWARD_EN
  logic [4:0] rs1_q, rs2_q;
  assign opa = (mem_regwrite && mem_rd == rs1_q && rs1_q != 5'd0) ? mem_result :
               (wb_regwrite  && wb_rd  == rs1_q && rs1_q != 5'd0) ? wb_result  : rd1_q;
  assign opb = (mem_regwrite && mem_rd == rs2_q && rs2_q != 5'd0) ? mem_result :
               (wb_regwrite  && wb_rd  == rs2_q && rs2_q != 5'd0) ? wb_result  : rd2_q;
  assign id_ready = ~valid_q | ex_ready;
`else
  logic haz1, haz2, unused_ok;
  assign opa = rd1_q;
  assign opb = rd2_q;
  // WB hazards are absorbed by the write-first register file
  assign haz1 = id_rs1 != 5'd0 && ((valid_q && regwrite_q && rd_q == id_rs1) || (mem_regwrite && mem_rd == id_rs1));
  assign haz2 = id_rs2 != 5'd0 && ((valid_q && regwrite_q && rd_q == id_rs2) || (mem_regwrite && mem_rd == id_rs2));
  assign id_ready = (~valid_q | ex_ready) & ~haz1 & ~haz2;
  assign unused_ok = ^{wb_regwrite, wb_rd, wb_result, mem_result};
`endif
  assign load = id_valid & id_ready & ~flush;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
      alu_q      <= '0;
      alusrc_q   <= 1'b0;
      regwrite_q <= 1'b0;
`ifdef EX_FORWARD_EN
      rs1_q      <= '0;
      rs2_q      <= '0;
`endif
    end else begin
      valid_q <= flush ? 1'b0 : (load | (valid_q & ~ex_ready));
      if (load) begin
        pc_q       <= id_pc;
        rd1_q      <= id_rd1;
        rd2_q      <= id_rd2;
        imm_q      <= id_immext;
        rd_q       <= id_rd;
        alu_q      <= id_alucontrol;
        alusrc_q   <= id_alusrc;
        regwrite_q <= id_regwrite;
`ifdef EX_FORWARD_EN
        rs1_q      <= id_rs1;
        rs2_q      <= id_rs2;
`endif
      end
`ifdef EX_FORWARD_EN
      // capture producers that retire while the instruction is stalled
      else if (valid_q & ~ex_ready) begin
        rd1_q <= opa;
        rd2_q <= opb;
      end
`endif
    end
  end
  assign ex_valid      = valid_q;
  assign ex_srca       = opa;
  assign ex_srcb       = alusrc_q ? imm_q : opb;
  assign ex_writedata  = opb;
  assign ex_alucontrol = alu_q;
  assign ex_pc         = pc_q;
  assign ex_immext     = imm_q;
  assign ex_rd         = rd_q;
  assign ex_regwrite   = regwrite_q;
endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register and operand-forwarding stage for the pipelined RISC-V core. Captures decoded operands from the decode stage and resolves RAW hazards against the MEM and WB stages. Presents final `srca`/`srcb`/`alucontrol` to the ALU in the execute stage. Uses a valid/ready handshake toward decode and toward the downstream EX/MEM register, plus a flush input for branch or jump redirects.

## Interface
- `XLEN`, 32, datapath width
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `id_valid`  in  1  decode stage presents an instruction
- `id_ready`  out  1  stage can accept an instruction this cycle
- `id_pc`  in  XLEN  instruction PC
- `id_rd1`, `id_rd2`  in  XLEN  register-file read data
- `id_rs1`, `id_rs2`, `id_rd`  in  5  register indices
- `id_immext`  in  XLEN  sign-extended immediate
- `id_alusrc`  in  1  1: srcb = immediate; 0: srcb = rs2 value
- `id_alucontrol`  in  3  ALU operation code
- `id_regwrite`  in  1  instruction writes `rd`
- `mem_regwrite`, `mem_rd`, `mem_result`  in  1/5/XLEN  MEM-stage producer
- `wb_regwrite`, `wb_rd`, `wb_result`  in  1/5/XLEN  WB-stage producer
- `flush`  in  1  kill the held instruction and any incoming one
- `ex_ready`  in  1  downstream accepts the EX instruction
- `ex_valid`  out  1  EX outputs are valid
- `ex_srca`, `ex_srcb`  out  XLEN  ALU operands
- `ex_writedata`  out  XLEN  forwarded rs2 value (store data)
- `ex_alucontrol`  out  3  ALU operation
- `ex_pc`, `ex_immext`  out  XLEN  for branch-target adder
- `ex_rd`, `ex_regwrite`  out  5/1  destination passthrough

## Operation
- Transfer occurs when `id_valid & id_ready` and `flush` is low. All `id_*` fields are registered and `ex_valid` is set.
- `id_ready = ~ex_valid | ex_ready`, further gated by the interlock described under Configuration.
- If `ex_valid & ex_ready` and no new transfer occurs, `ex_valid` clears.
- Forwarding applies per operand (rs1 → srca, rs2 → writedata and, when `alusrc`=0, srcb):
  - If `mem_regwrite` and `mem_rd == rs` and `rs != 0`, use `mem_result`.
  - Otherwise, if `wb_regwrite` and `wb_rd == rs` and `rs != 0`, use `wb_result`.
  - Otherwise, use the stored register value.
  - MEM has priority over WB. x0 never forwards.
- Operand refresh: while `ex_valid & ~ex_ready`, the stored rd1/rd2 are overwritten every cycle with the forwarded values. A producer that retires during the stall therefore does not lose its value.
- Flush:
  - `ex_valid` is 0 the next cycle, whatever `ex_ready` is.
  - An instruction being transferred in the same cycle is dropped.
  - Flush has priority over load.
- `ex_srcb = alusrc ? immext : fwd_rs2`.

## Timing
- Latency is 1 cycle from decode handshake to `ex_valid`.
- Forwarding muxes are combinational from the MEM/WB inputs to the `ex_*` operands within the same cycle.
- Throughput is one instruction per cycle when `ex_ready` is held high.
- Reset (asynchronous, `reset_n`=0): every register clears to 0. Outputs are therefore `ex_valid`=0, `ex_srca`=`ex_srcb`=`ex_writedata`=0, `ex_alucontrol`=0, `ex_pc`=0, `ex_immext`=0, `ex_rd`=0, `ex_regwrite`=0, and `id_ready`=1.
- Reset asserted mid-stall discards the held instruction immediately.
- `id_ready` depends combinationally on `ex_ready`. There is no combinational path from `id_valid` to `id_ready`.

## Configuration
- `EX_FORWARD_EN` defined:
  - The MEM/WB forwarding muxes and operand refresh are present.
  - `id_ready` is as stated above.
- `EX_FORWARD_EN` undefined:
  - No forwarding. Operands come straight from the stored register values.
  - Decode interlock: `id_ready` is forced to 0 when the decode rs1 or rs2 is non-zero and equals either of:
    - `ex_rd` with `ex_valid & ex_regwrite`
    - `mem_rd` with `mem_regwrite`
  - The WB hazard is covered by the register file's write-first behaviour.

## Test plan
- Reset, then an `add` with rd1=5, rd2=7, `alusrc`=0, no hazards → one cycle later `ex_valid`=1, `ex_srca`=5, `ex_srcb`=7, `ex_alucontrol`=000.
- rs1=3 with `mem_rd`=3 (result 0x11) and `wb_rd`=3 (result 0x22), both regwrite → `ex_srca`=0x11. With MEM regwrite dropped → `ex_srca`=0x22.
- rs1=0, `mem_rd`=0, `mem_regwrite`=1, `mem_result`=0xFF → `ex_srca` equals the stored rd1 (0).
- `ex_ready`=0 for 3 cycles while `wb_rd`=rs2 with `wb_result`=0x40 in cycle 1 only, then `ex_ready`=1 → `ex_writedata`=0x40 at release. `id_ready`=0 throughout the stall.
- `flush`=1 in the same cycle as `id_valid`=1 and `id_ready`=1 → `ex_valid`=0 next cycle, and the incoming instruction never appears.
- `EX_FORWARD_EN` undefined, EX holds rd=4 with regwrite, decode rs2=4 → `id_ready`=0 until EX drains, then the transfer completes with the register-file value.
